// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: address width, NOP encoding, PC step
// and the fetch queue entry layout.
package riscv_pkg;
  localparam int          XLEN      = 64;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          PC_STEP   = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO holding fetched {pc, instr} pairs.
// Flush empties it in one edge and overrides any push/pop.
module fetch_queue #(
  parameter type entry_t = riscv_pkg::fetch_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count
);
  entry_t mem [2];
  logic   wr_ptr, rd_ptr;
  logic   do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // When full with a pop, wr_ptr == rd_ptr: the head is read this cycle and
  // overwritten on the edge, so the slot is reused without a hazard.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, feeds a 2-entry queue from
// instruction_memory and presents the head to decode with valid/ready.
module fetch_ctrl #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [XLEN-1:0]  if_pc,
  output logic [31:0]      if_instr,
  output logic             misalign_err,
  output logic [CNT_W-1:0] stall_cnt
);
  import riscv_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [1:0]      count;
  logic            pop, push;
  entry_t          din, head;

  assign imem_addr = fetch_pc;
  assign if_valid  = (count != 2'd0);
  assign pop       = if_valid && if_ready;
  assign push      = fetch_en && !redirect_valid && ((count != 2'd2) || pop);
  assign din       = '{pc: fetch_pc, instr: imem_instr};
  assign if_pc     = if_valid ? head.pc : '0;
  assign if_instr  = if_valid ? head.instr : NOP_INSTR;

  fetch_queue #(.entry_t(entry_t)) u_q (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      // Redirect wins over sequential fetch; low bits are dropped, not trapped.
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end else if (push) begin
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
      if (if_valid && !if_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the RISC-V core. It owns the fetch PC and drives the combinational `instruction_memory` address port. It captures each returned word with its PC into a 2-entry fetch queue and presents entries to decode over a valid/ready handshake. It handles branch/jump redirects, flushes, fetch enable and stall accounting; it sits between `instruction_memory` and the decode stage.

## Interface
Parameters:
- `XLEN`, 64: PC / address width.
- `RESET_PC`, 64'h0: fetch PC loaded on reset.
- `CNT_W`, 32: stall counter width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  permits new fetches; queue still drains when low.
- `imem_addr`  out  XLEN  address to `instruction_memory` (= fetch PC).
- `imem_instr`  in  32  instruction word for `imem_addr`, same-cycle combinational.
- `redirect_valid`  in  1  branch/jump/flush request.
- `redirect_pc`  in  XLEN  target PC.
- `if_valid`  out  1  queue head valid.
- `if_ready`  in  1  decode accepts head.
- `if_pc`  out  XLEN  PC of head entry (0 when empty).
- `if_instr`  out  32  instruction of head entry (32'h00000013 NOP when empty).
- `misalign_err`  out  1  sticky: a redirect target had `[1:0]` != 0.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `if_valid && !if_ready`.

## Operation
- State: `fetch_pc`, 2-entry queue {pc, instr} with `count` 0..2, `misalign_err`, `stall_cnt`.
- `imem_addr = fetch_pc` at all times.
- pop = `if_valid && if_ready`.
- push = `fetch_en && !redirect_valid && (count < 2 || pop)`.
- On push: enqueue {fetch_pc, imem_instr}; `fetch_pc <= fetch_pc + 4`. Modulo 2^XLEN, so `2^64-4` wraps to 0.
- Push and pop in the same cycle:
  - `count` is unchanged.
  - Order is preserved (FIFO).
- Redirect (priority over everything):
  - Queue is flushed (`count <= 0`).
  - Any same-cycle pop is discarded and no push occurs.
  - `fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}`.
  - If `redirect_pc[1:0] != 0`, then `misalign_err <= 1` and stays set until reset.
- Stall counter:
  - `stall_cnt` increments when `if_valid && !if_ready`.
  - It saturates at all-ones.
  - Redirect does not clear it.
- `fetch_en` low: no push and `fetch_pc` holds. Head pops proceed normally.

## Timing
- Reset values: `fetch_pc = RESET_PC`, `count = 0`, `if_valid = 0`, `if_pc = 0`, `if_instr = 32'h00000013`, `misalign_err = 0`, `stall_cnt = 0`. `imem_addr = RESET_PC`.
- Reset asserted mid-operation returns all state to the reset values on that edge; redirect and push in the same cycle are ignored.
- Fetch-to-decode latency: a word fetched in cycle N is presented as head (`if_valid` = 1) in cycle N+1. The first `if_valid` appears 1 cycle after reset deasserts.
- Throughput: 1 instruction/cycle with `if_ready` held high and `fetch_en` high.
- Queue full (`count == 2`) and `!if_ready`: no fetch, `fetch_pc` holds, and `imem_addr` is stable.
- Redirect in cycle N: `if_valid = 0` in N+1 and the target instruction is the head in N+2 (2-cycle bubble).
- Outputs `if_*` are registered queue contents, with no combinational path from `imem_instr`. `imem_addr` is registered.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `NOP_INSTR` (32'h00000013), `PC_STEP` (4), and a typedef `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_queue`: a 2-entry synchronous FIFO with push/pop/flush, count, and a head output. `fetch_ctrl` holds the PC, redirect, error and counter logic.

## Test plan
- Reset then stream with `if_ready = 1` over the standard program image:
  - Cycle 1: `if_pc = 0`, `if_instr = 00700013` (addi x0,x0,7).
  - Cycle 2: `if_pc = 4`, `if_instr = 0dc00693` (addi x13,x0,220).
  - Consecutive PCs 0, 4, 8, … with no gaps.
- Backpressure: hold `if_ready = 0` for 5 cycles after the first valid.
  - `count` reaches 2 and `imem_addr` freezes at 8.
  - `stall_cnt = 5`.
  - On release, PCs 0, 4, 8 are delivered in order with no loss or duplicate.
- Redirect to 32 while the queue is full and `if_ready = 1`:
  - Next cycle `if_valid = 0`.
  - Following cycle head `if_pc = 32` (ld x26,32(x0)), then 36 and 40.
- Misaligned redirect to 46: `misalign_err` = 1 sticky, and the next head `if_pc = 44` (addi x1,x0,21).
- Wrap and enable:
  - Redirect to 64'hFFFF_FFFF_FFFF_FFFC gives heads …FFFC then 0.
  - Dropping `fetch_en` lets the queue drain to `if_valid = 0` with `imem_addr` held.
- Reset asserted mid-stream with a pending redirect: after the edge, `count = 0`, `imem_addr = RESET_PC`, `stall_cnt = 0`, and `misalign_err = 0`.
